// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiply controller: op encoding, FSM states,
// multiplier latency and the operand-signedness / result-selection rules.
package mul_pkg;

  localparam int MUL_LATENCY = 64;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } mul_state_e;

  // Word form always multiplies zero-extended halves, so it is never signed.
  function automatic logic src1_signed(input mul_op_e op, input logic op_w);
    return !op_w && (op == OP_MULH || op == OP_MULHSU);
  endfunction

  function automatic logic src2_signed(input mul_op_e op, input logic op_w);
    return !op_w && (op == OP_MULH);
  endfunction

  function automatic logic [63:0] mul_select(input mul_op_e op, input logic op_w,
                                             input logic [127:0] prod);
    logic [63:0] sel;
    if (op_w)
      sel = {{32{prod[31]}}, prod[31:0]};
    else if (op == OP_MUL)
      sel = prod[63:0];
    else
      sel = prod[127:64];
    return sel;
  endfunction

endpackage

// File: rtl/mul_negate.sv
// Conditional two's-complement negation; gives |x| for a signed operand and
// restores the sign of the unsigned product.
module mul_negate
  import mul_pkg::*;
#(
  parameter int W = 128
) (
  input  logic [W-1:0] i_data,
  input  logic         i_neg,
  output logic [W-1:0] o_data
);

  logic [W-1:0] w_one;
  assign w_one  = {{(W-1){1'b0}}, 1'b1};
  // The most negative value maps to itself, which reads correctly as unsigned 2^(W-1).
  assign o_data = i_neg ? (~i_data + w_one) : i_data;

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer wrapping an unsigned 64-cycle shift-add multiplier to provide the
// RISC-V MUL/MULH/MULHSU/MULHU/MULW family with valid/ready handshakes.
module mul_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        op_w,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        mul_valid,
  output logic [63:0] multiplicand,
  output logic [63:0] multiplier,
  input  logic        mul_out_valid,
  input  logic [63:0] result_h,
  input  logic [63:0] result_l
);

  mul_op_e      w_op;
  logic [63:0]  w_src1_m;
  logic [63:0]  w_src2_m;
  logic         w_neg1;
  logic         w_neg2;
  logic [63:0]  w_abs1;
  logic [63:0]  w_abs2;
  logic         w_zero;
  logic [127:0] w_prod_fixed;

  mul_state_e   r_state;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [63:0]  r_out_data;
  logic         r_mul_valid;
  logic [63:0]  r_multiplicand;
  logic [63:0]  r_multiplier;
  logic [127:0] r_prod;
  logic         r_neg;
  mul_op_e      r_op;
  logic         r_op_w;

  assign w_op     = mul_op_e'(op);
  assign w_src1_m = op_w ? {32'd0, src1[31:0]} : src1;
  assign w_src2_m = op_w ? {32'd0, src2[31:0]} : src2;
  assign w_neg1   = src1_signed(w_op, op_w) && w_src1_m[63];
  assign w_neg2   = src2_signed(w_op, op_w) && w_src2_m[63];
  assign w_zero   = (w_src1_m == 64'd0) || (w_src2_m == 64'd0);

  mul_negate #(.W(64)) u_abs1 (
    .i_data (w_src1_m),
    .i_neg  (w_neg1),
    .o_data (w_abs1)
  );

  mul_negate #(.W(64)) u_abs2 (
    .i_data (w_src2_m),
    .i_neg  (w_neg2),
    .o_data (w_abs2)
  );

  mul_negate #(.W(128)) u_prod_sign (
    .i_data (r_prod),
    .i_neg  (r_neg),
    .o_data (w_prod_fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_data     <= 64'd0;
      r_mul_valid    <= 1'b0;
      r_multiplicand <= 64'd0;
      r_multiplier   <= 64'd0;
      r_prod         <= 128'd0;
      r_neg          <= 1'b0;
      r_op           <= OP_MUL;
      r_op_w         <= 1'b0;
    end else begin
      r_mul_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready && !flush) begin
            r_op       <= w_op;
            r_op_w     <= op_w;
            r_neg      <= w_neg1 ^ w_neg2;
            r_in_ready <= 1'b0;
            if (w_zero) begin
              r_out_data  <= 64'd0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_multiplicand <= w_abs1;
              r_multiplier   <= w_abs2;
              r_mul_valid    <= 1'b1;
              r_state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          // A flush coinciding with the result pulse has nothing left to drain.
          if (flush) begin
            if (mul_out_valid) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end else if (mul_out_valid) begin
            r_prod  <= {result_h, result_l};
            r_state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_out_data  <= mul_select(r_op, r_op_w, w_prod_fixed);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        DRAIN: begin
          if (mul_out_valid) begin
            r_in_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign mul_valid    = r_mul_valid;
  assign multiplicand = r_multiplicand;
  assign multiplier   = r_multiplier;

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural 64-cycle multiplier and
// an arithmetic reference model of the RISC-V multiply ops.
module tb_mul_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic        op_w = 1'b0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        mul_valid;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        mul_out_valid;
  logic [63:0] result_h;
  logic [63:0] result_l;

  int n_assert = 0;
  int n_fail   = 0;
  int mv_total = 0;

  always #5 clk = ~clk;

  mul_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_w(op_w), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mul_valid(mul_valid), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_out_valid(mul_out_valid), .result_h(result_h), .result_l(result_l)
  );

  // Multiplier model: samples mul_valid, pulses mul_out_valid 64 cycles later.
  logic         m_rst_n;
  logic [6:0]   m_cnt;
  logic [127:0] m_prod;
  assign m_rst_n = ~rst;

  always @(posedge clk) begin
    if (!m_rst_n) begin
      m_cnt         <= 7'd0;
      mul_out_valid <= 1'b0;
      m_prod        <= 128'd0;
    end else begin
      mul_out_valid <= (m_cnt == 7'd1);
      if (mul_valid && m_cnt == 7'd0) begin
        m_cnt  <= 7'(MUL_LATENCY - 1);
        m_prod <= {64'd0, multiplicand} * {64'd0, multiplier};
      end else if (m_cnt != 7'd0) begin
        m_cnt <= m_cnt - 7'd1;
      end
    end
    if (m_rst_n && m_cnt == 7'd1) {result_h, result_l} <= m_prod;
    else {result_h, result_l} <= {$urandom, $urandom, $urandom, $urandom};
    if (mul_valid) mv_total <= mv_total + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] x, y, p;
    logic [63:0]  pw;
    if (w) begin
      pw = {32'd0, a[31:0]} * {32'd0, b[31:0]};
      return {{32{pw[31]}}, pw[31:0]};
    end
    case (o)
      2'b00: begin x = {64'd0, a}; y = {64'd0, b}; p = x * y; return p[63:0]; end
      2'b01: begin x = {{64{a[63]}}, a}; y = {{64{b[63]}}, b}; p = x * y; return p[127:64]; end
      2'b10: begin x = {{64{a[63]}}, a}; y = {64'd0, b}; p = x * y; return p[127:64]; end
      default: begin x = {64'd0, a}; y = {64'd0, b}; p = x * y; return p[127:64]; end
    endcase
  endfunction

  function automatic logic ref_zero(input logic w, input logic [63:0] a, input logic [63:0] b);
    return w ? (a[31:0] == 32'd0 || b[31:0] == 32'd0) : (a == 64'd0 || b == 64'd0);
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'($urandom_range(0, 20));
      4: return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op and return in cycle 1 (one step after the accept edge).
  task automatic issue(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin step(); t++; end
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; op = o; op_w = w; src1 = a; src2 = b;
    step();
    in_valid = 1'b0;
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic w,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int stall);
    int mv0, lat;
    logic zero;
    logic [63:0] held;
    zero = ref_zero(w, a, b);
    mv0 = mv_total;
    issue(tag, o, w, a, b);
    chk({tag, "_mulv_c1"}, mul_valid, zero ? 0 : 1);
    lat = 1;
    while (!out_valid && lat < 300) begin step(); lat++; end
    chk({tag, "_lat"}, 64'(lat), zero ? 64'd1 : 64'd67);
    chk({tag, "_data"}, out_data, exp);
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_stall_data"}, out_data, held);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk({tag, "_stall_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
    chk({tag, "_mulv_count"}, 64'(mv_total - mv0), zero ? 64'd0 : 64'd1);
    $display("op %s: op=%0d w=%0d a=%h b=%h -> %h (lat %0d)", tag, o, w, a, b, held, lat);
  endtask

  // In DRAIN: hold-off until the multiplier pulse, then ready on the next cycle.
  task automatic drain_check(input string tag);
    int  t = 0;
    logic seen = 1'b0;
    while (!seen && t < 200) begin
      chk({tag, "_drain_ready"}, in_ready, 0);
      chk({tag, "_drain_valid"}, out_valid, 0);
      if (mul_out_valid) seen = 1'b1;
      step();
      t++;
    end
    chk({tag, "_pulse_seen"}, seen, 1);
    chk({tag, "_ready_after"}, in_ready, 1);
    chk({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_multiplicand", multiplicand, 0);
    chk("rst_multiplier", multiplier, 0);
    rst = 1'b0;
    step();

    run("mulh_neg", 2'b01, 1'b0, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("mulhu_max", 2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run("mul_max", 2'b00, 1'b0, '1, '1, 64'h1, 0);
    run("mulw_ovf", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run("mulhsu_neg", 2'b10, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("zero_short", 2'b00, 1'b0, 64'd0, 64'd5, 64'd0, 0);
    run("mulw_hi_zero", 2'b00, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd5, 64'd0, 0);
    run("mulh_minint", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        64'h4000_0000_0000_0000, 0);
    run("stall5", 2'b00, 1'b0, 64'd1234, 64'd5678, 64'd7006652, 5);

    // Flush on the 10th WAIT cycle.
    issue("fl_wait", 2'b00, 1'b0, 64'd9, 64'd11);
    for (int i = 0; i < 10; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    drain_check("fl_wait");
    run("after_fl_wait", 2'b01, 1'b0, -64'sd5, -64'sd6, 64'd0, 0);

    // Flush in ISSUE: the pulse still completes.
    issue("fl_issue", 2'b11, 1'b0, 64'd3, 64'd4);
    chk("fl_issue_mulv", mul_valid, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_issue_mulv_off", mul_valid, 0);
    drain_check("fl_issue");

    // Flush in FIX (cycle 66) discards the result.
    issue("fl_fix", 2'b00, 1'b0, 64'd3, 64'd4);
    for (int i = 0; i < 65; i++) step();
    chk("fl_fix_pre_valid", out_valid, 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_fix_valid", out_valid, 0);
    chk("fl_fix_ready", in_ready, 1);
    step();
    chk("fl_fix_valid2", out_valid, 0);

    // Flush in DONE.
    issue("fl_done", 2'b00, 1'b0, 64'd0, 64'd3);
    chk("fl_done_valid_c1", out_valid, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("fl_done_valid", out_valid, 0);
    chk("fl_done_ready", in_ready, 1);

    // Flush in IDLE blocks the accept.
    in_valid = 1'b1; src1 = 64'd7; src2 = 64'd8; op = 2'b00; op_w = 1'b0; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_ready", in_ready, 1);
    chk("fl_idle_mulv", mul_valid, 0);
    chk("fl_idle_valid", out_valid, 0);

    // in_valid during the DONE handshake is not accepted.
    issue("done_hs", 2'b00, 1'b0, 64'd5, 64'd0);
    in_valid = 1'b1; src1 = 64'd7; src2 = 64'd8; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("done_hs_valid", out_valid, 0);
    chk("done_hs_ready", in_ready, 1);
    chk("done_hs_mulv", mul_valid, 0);

    // Reset in WAIT.
    issue("rst_wait", 2'b00, 1'b0, 64'd100, 64'd200);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_wait_ready", in_ready, 1);
    chk("rst_wait_valid", out_valid, 0);
    chk("rst_wait_mulv", mul_valid, 0);
    chk("rst_wait_mcand", multiplicand, 0);
    run("after_rst", 2'b10, 1'b0, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    for (int k = 0; k < 25; k++) begin
      ro = 2'($urandom_range(0, 3));
      rw = ($urandom_range(0, 3) == 0);
      ra = rnd_operand();
      rb = rnd_operand();
      run($sformatf("rnd%0d", k), ro, rw, ra, rb, ref_mul(ro, rw, ra, rb),
          int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
